ram_burst_master: RTL and testbench

Burst command sequencer that drives the single-port RAM's `address`/`data`/`wren`/`q` port from the initiator side. It accepts one read or write burst command at a time and sequences consecutive RAM accesses at one word per clock. Write data arrives on a ready/valid stream. Read data leaves on a valid-only stream, aligned to the RAM's one-cycle registered `q`. It sits between datapath logic and the RAM, making the RAM's access timing invisible to upstream blocks.

---
 rtl/ram_burst_master.sv | 103 ++++++++++
 tb/tb_ram_burst_master.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/ram_burst_master.sv
// Burst command sequencer for a single-port RAM with a one-cycle registered q.
// Write words stream in on ready/valid; read words stream out valid-only.
module ram_burst_master #(
  parameter int data_width = 8,
  parameter int addr_width = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [addr_width-1:0] cmd_addr,
  input  logic [addr_width-1:0] cmd_len,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [data_width-1:0] wr_data,
  output logic                  rd_valid,
  output logic [data_width-1:0] rd_data,
  output logic                  busy,
  output logic                  done,
  output logic [addr_width-1:0] ram_address,
  output logic [data_width-1:0] ram_data,
  output logic                  ram_wren,
  input  logic [data_width-1:0] ram_q
);

  typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;

  state_t                state_q, state_d;
  logic [addr_width-1:0] cur_addr_q, cur_addr_d;
  logic [addr_width-1:0] remaining_q, remaining_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  done_q, done_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      cur_addr_q  <= '0;
      remaining_q <= '0;
      rd_valid_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      remaining_q <= remaining_d;
      rd_valid_q  <= rd_valid_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cur_addr_d  = cur_addr_q;
    remaining_d = remaining_q;
    rd_valid_d  = 1'b0;
    done_d      = 1'b0;
    cmd_ready   = 1'b0;
    wr_ready    = 1'b0;
    ram_wren    = 1'b0;
    case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          cur_addr_d  = cmd_addr;
          remaining_d = cmd_len;
          state_d     = cmd_write ? WRITE : READ;
        end
      end
      WRITE: begin
        wr_ready = 1'b1;
        // Reset is synchronous, so gate the strobe to block a write on the reset edge itself.
        ram_wren = wr_valid & ~reset;
        if (wr_valid) begin
          cur_addr_d  = cur_addr_q + addr_width'(1);
          remaining_d = remaining_q - addr_width'(1);
          if (remaining_q == '0) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      READ: begin
        rd_valid_d = 1'b1;
        cur_addr_d = cur_addr_q + addr_width'(1);
        if (remaining_q == '0) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          remaining_d = remaining_q - addr_width'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign rd_valid    = rd_valid_q;
  assign rd_data     = ram_q;
  assign ram_address = cur_addr_q;
  assign ram_data    = wr_data;

endmodule

// File: tb/tb_ram_burst_master.sv
// Directed bench for ram_burst_master with a behavioural single-port RAM (registered q).
module tb_ram_burst_master;

  logic       clock = 1'b0;
  logic       reset;
  logic       cmd_valid, cmd_ready, cmd_write;
  logic [7:0] cmd_addr, cmd_len;
  logic       wr_valid, wr_ready;
  logic [7:0] wr_data;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic       busy, done;
  logic [7:0] ram_address, ram_data, ram_q;
  logic       ram_wren;

  logic       ld_en;
  logic [7:0] ld_addr, ld_data;
  logic [7:0] mem [256];

  int total, bad;

  always #5 clock = ~clock;

  ram_burst_master #(.data_width(8), .addr_width(8)) dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_data(rd_data),
    .busy(busy), .done(done),
    .ram_address(ram_address), .ram_data(ram_data), .ram_wren(ram_wren), .ram_q(ram_q)
  );

  always_ff @(posedge clock) begin
    if (ld_en) mem[ld_addr] <= ld_data;
    else if (ram_wren) mem[ram_address] <= ram_data;
    ram_q <= mem[ram_address];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic nextc;
    @(posedge clock);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] wd [4];
    logic [7:0] vp [4];
    logic [7:0] dd [4];
    logic [7:0] a;
    int nw;
    wd = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
    vp = '{8'd1, 8'd0, 8'd0, 8'd1};
    dd = '{8'h55, 8'h00, 8'h00, 8'h66};
    total = 0; bad = 0;
    reset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
    wr_valid = 1'b0; wr_data = '0; ld_en = 1'b1; ld_addr = '0; ld_data = '0;

    // Load RAM image mem[i]=i while reset is held.
    for (int i = 0; i < 256; i++) begin
      ld_addr = 8'(i); ld_data = 8'(i);
      nextc;
    end
    ld_en = 1'b0; wr_valid = 1'b1; wr_data = 8'h99;
    #1;
    chk("wren_in_reset", ram_wren, 0);
    chk("wrdata_passthru", ram_data, 8'h99);
    nextc;
    reset = 1'b0; wr_valid = 1'b0;
    #1;
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_wr_ready", wr_ready, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_wren", ram_wren, 0);
    chk("rst_addr", ram_address, 0);

    // Full-depth read.
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h00; cmd_len = 8'hFF;
    #1 chk("d_cmd_ready", cmd_ready, 1);
    nextc; cmd_valid = 1'b0;
    #1;
    chk("d_busy", busy, 1);
    chk("d_rv_first", rd_valid, 0);
    chk("d_addr0", ram_address, 0);
    for (int i = 0; i < 256; i++) begin
      nextc; #1;
      chk("d_rv", rd_valid, 1);
      chk("d_data", rd_data, i);
      chk("d_done", done, (i == 255) ? 1 : 0);
      chk("d_ready", cmd_ready, (i == 255) ? 1 : 0);
    end
    nextc; #1;
    chk("d_rv_end", rd_valid, 0);
    chk("d_done_end", done, 0);
    chk("d_ready_end", cmd_ready, 1);

    // Write wrap FE..01, then read it back with the command accepted in the done cycle.
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'hFE; cmd_len = 8'd3;
    wr_valid = 1'b1; wr_data = wd[0];
    #1;
    chk("a_cmd_ready", cmd_ready, 1);
    chk("a_wren_idle", ram_wren, 0);
    for (int i = 0; i < 4; i++) begin
      nextc; cmd_valid = 1'b0; wr_data = wd[i];
      #1;
      chk("a_wren", ram_wren, 1);
      chk("a_wr_ready", wr_ready, 1);
      chk("a_addr", ram_address, 8'(8'hFE + i));
      chk("a_done", done, 0);
      chk("a_busy", busy, 1);
    end
    nextc; wr_valid = 1'b0;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'hFE; cmd_len = 8'd3;
    #1;
    chk("a_done_pulse", done, 1);
    chk("a_ready_done", cmd_ready, 1);
    chk("a_wren_after", ram_wren, 0);
    for (int i = 0; i < 4; i++) begin
      nextc; cmd_valid = 1'b0;
      #1;
      chk("b_addr", ram_address, 8'(8'hFE + i));
      chk("b_wren", ram_wren, 0);
      chk("b_rv", rd_valid, (i > 0) ? 1 : 0);
      if (i > 0) chk("b_data", rd_data, wd[i-1]);
      chk("b_done", done, 0);
    end
    nextc; #1;
    chk("b_rv_last", rd_valid, 1);
    chk("b_data_last", rd_data, wd[3]);
    chk("b_done_last", done, 1);
    nextc; #1;
    chk("b_rv_end", rd_valid, 0);
    chk("b_done_end", done, 0);
    for (int i = 0; i < 4; i++) begin
      a = 8'(8'hFE + i);
      chk("a_mem", mem[a], wd[i]);
    end

    // Stalled 2-word write to 0x10.
    nw = 0;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h10; cmd_len = 8'd1; wr_valid = 1'b0;
    #1;
    chk("c_cmd_ready", cmd_ready, 1);
    nw += int'(ram_wren);
    for (int i = 0; i < 4; i++) begin
      nextc; cmd_valid = 1'b0; wr_valid = vp[i][0]; wr_data = dd[i];
      #1;
      chk("c_busy", busy, 1);
      chk("c_wren", ram_wren, vp[i]);
      chk("c_addr", ram_address, (i == 0) ? 8'h10 : 8'h11);
      chk("c_done", done, 0);
      nw += int'(ram_wren);
    end
    nextc; wr_valid = 1'b0;
    #1;
    chk("c_done_pulse", done, 1);
    chk("c_busy_end", busy, 0);
    nw += int'(ram_wren);
    nextc; #1;
    nw += int'(ram_wren);
    chk("c_wren_count", nw, 2);
    chk("c_mem10", mem[8'h10], 8'h55);
    chk("c_mem11", mem[8'h11], 8'h66);

    // Reset after 2 of 8 words at 0x40.
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h40; cmd_len = 8'd7;
    wr_valid = 1'b1; wr_data = 8'hE0;
    nextc; cmd_valid = 1'b0; wr_data = 8'hE0;
    #1 chk("e_wren0", ram_wren, 1);
    nextc; wr_data = 8'hE1;
    #1 chk("e_wren1", ram_wren, 1);
    nextc; reset = 1'b1; wr_data = 8'hE2;
    #1 chk("e_wren_rst", ram_wren, 0);
    nextc; reset = 1'b0; wr_valid = 1'b0;
    #1;
    chk("e_cmd_ready", cmd_ready, 1);
    chk("e_busy", busy, 0);
    chk("e_wr_ready", wr_ready, 0);
    chk("e_done", done, 0);
    for (int i = 0; i < 3; i++) begin
      nextc; #1;
      chk("e_no_done", done, 0);
    end
    chk("e_mem40", mem[8'h40], 8'hE0);
    chk("e_mem41", mem[8'h41], 8'hE1);
    chk("e_mem42", mem[8'h42], 8'h42);
    chk("e_mem47", mem[8'h47], 8'h47);

    // Back-to-back write then read of 0x7F.
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h7F; cmd_len = 8'd0;
    wr_valid = 1'b1; wr_data = 8'hC3;
    nextc; cmd_valid = 1'b0;
    #1;
    chk("f_wren", ram_wren, 1);
    chk("f_addr", ram_address, 8'h7F);
    nextc; wr_valid = 1'b0;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h7F; cmd_len = 8'd0;
    #1;
    chk("f_done_w", done, 1);
    chk("f_ready", cmd_ready, 1);
    nextc; cmd_valid = 1'b0;
    #1;
    chk("f_raddr", ram_address, 8'h7F);
    chk("f_busy", busy, 1);
    nextc; #1;
    chk("f_rv", rd_valid, 1);
    chk("f_data", rd_data, 8'hC3);
    chk("f_done_r", done, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
